// File: rtl/time_keeper.sv
// BCD HH:MM:SS 24 h time-of-day counter with a single alarm that rings until acked or timed out.
// Latency 1 cycle (all outputs registered); no backpressure, every accepted tick is consumed at once.
module time_keeper #(
    parameter int unsigned ALARM_LEN = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ena,
    input  logic       set_time,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic       set_alarm,
    input  logic [7:0] alm_hh,
    input  logic [7:0] alm_mm,
    input  logic       alarm_en,
    input  logic       ack,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       alarm_active,
    output logic       set_err
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RINGING = 1'b1;
    localparam logic [7:0] RING_LAST = 8'(ALARM_LEN - 1);

    logic [0:0] state;
    logic [7:0] ring_cnt;
    logic [7:0] alm_hh_q, alm_mm_q;

    logic       time_ok, alm_ok, acc_tick;
    logic       ss_wrap, mm_wrap, alarm_hit;
    logic [7:0] hh_nxt, mm_nxt, ss_nxt;

    // Valid BCD nibbles make numeric comparison of the packed byte order-correct.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        time_ok  = bcd_ok(set_hh, 8'h23) && bcd_ok(set_mm, 8'h59) && bcd_ok(set_ss, 8'h59);
        alm_ok   = bcd_ok(alm_hh, 8'h23) && bcd_ok(alm_mm, 8'h59);
        acc_tick = tick & ena & ~set_time;

        ss_wrap = (ss == 8'h59);
        mm_wrap = (mm == 8'h59);
        ss_nxt  = ss_wrap ? 8'h00 : bcd_inc(ss);
        mm_nxt  = ss_wrap ? (mm_wrap ? 8'h00 : bcd_inc(mm)) : mm;
        hh_nxt  = (ss_wrap && mm_wrap) ? ((hh == 8'h23) ? 8'h00 : bcd_inc(hh)) : hh;

        // Only a counted tick can trigger; loading a matching time never rings.
        alarm_hit = acc_tick & alarm_en & (hh_nxt == alm_hh_q) & (mm_nxt == alm_mm_q)
                    & (ss_nxt == 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hh        <= 8'h00;
            mm        <= 8'h00;
            ss        <= 8'h00;
            alm_hh_q  <= 8'h00;
            alm_mm_q  <= 8'h00;
            sec_pulse <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            if (set_time) begin
                if (time_ok) begin
                    hh <= set_hh;
                    mm <= set_mm;
                    ss <= set_ss;
                end
            end else if (acc_tick) begin
                hh <= hh_nxt;
                mm <= mm_nxt;
                ss <= ss_nxt;
            end
            if (set_alarm && alm_ok) begin
                alm_hh_q <= alm_hh;
                alm_mm_q <= alm_mm;
            end
            sec_pulse <= acc_tick;
            set_err   <= (set_time & ~time_ok) | (set_alarm & ~alm_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ring_cnt <= 8'd0;
        end else if (state == IDLE) begin
            if (alarm_hit) begin
                state    <= RINGING;
                ring_cnt <= 8'd0;
            end
        end else begin
            if (ack || !alarm_en) begin
                state <= IDLE;
            end else if (acc_tick) begin
                ring_cnt <= ring_cnt + 8'd1;
                if (ring_cnt == RING_LAST)
                    state <= IDLE;
            end
        end
    end

    assign alarm_active = (state == RINGING);

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboarded random/directed bench for time_keeper against a seconds-of-day reference model.
module tb_time_keeper;

    localparam int ALEN = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, ena = 1'b1, set_time = 1'b0, set_alarm = 1'b0;
    logic       alarm_en = 1'b0, ack = 1'b0;
    logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
    logic [7:0] alm_hh = 8'h00, alm_mm = 8'h00;
    logic [7:0] hh, mm, ss;
    logic       sec_pulse, alarm_active, set_err;

    time_keeper #(.ALARM_LEN(ALEN)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .ena(ena),
        .set_time(set_time), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .set_alarm(set_alarm), .alm_hh(alm_hh), .alm_mm(alm_mm),
        .alarm_en(alarm_en), .ack(ack),
        .hh(hh), .mm(mm), .ss(ss), .sec_pulse(sec_pulse),
        .alarm_active(alarm_active), .set_err(set_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          tag;
        logic [26:0] v;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // Reference model: time as seconds of day, alarm as minute of day.
    int t_sec = 0;
    int alm_min = 0;
    bit ringing = 0;
    int rcnt = 0;
    bit m_pulse = 0;
    bit m_err = 0;

    function automatic int bcd_val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit legal(input logic [7:0] v, input int max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd_val(v) <= max_v);
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    function automatic logic [26:0] exp_vec();
        return {to_bcd(t_sec / 3600), to_bcd((t_sec / 60) % 60), to_bcd(t_sec % 60),
                m_pulse, ringing, m_err};
    endfunction

    task automatic model_step();
        bit acc, lt, la;
        acc = tick && ena && !set_time;
        lt  = legal(set_hh, 23) && legal(set_mm, 59) && legal(set_ss, 59);
        la  = legal(alm_hh, 23) && legal(alm_mm, 59);
        m_err   = (set_time && !lt) || (set_alarm && !la);
        m_pulse = acc;
        if (!ringing) begin
            if (acc && alarm_en && ((t_sec + 1) % 86400) == alm_min * 60) begin
                ringing = 1;
                rcnt = 0;
            end
        end else if (ack || !alarm_en) begin
            ringing = 0;
        end else if (acc) begin
            rcnt++;
            if (rcnt == ALEN) ringing = 0;
        end
        if (set_alarm && la) alm_min = bcd_val(alm_hh) * 60 + bcd_val(alm_mm);
        if (set_time && lt)
            t_sec = bcd_val(set_hh) * 3600 + bcd_val(set_mm) * 60 + bcd_val(set_ss);
        else if (acc)
            t_sec = (t_sec + 1) % 86400;
    endtask

    task automatic step();
        exp_t e;
        model_step();
        e.tag = cyc + 1;
        e.v   = exp_vec();
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                               input logic tk);
        set_time = 1'b1; set_hh = h; set_mm = m; set_ss = s; tick = tk;
        step();
        set_time = 1'b0; tick = 1'b0;
    endtask

    task automatic do_set_alarm(input logic [7:0] h, input logic [7:0] m);
        set_alarm = 1'b1; alm_hh = h; alm_mm = m;
        step();
        set_alarm = 1'b0;
    endtask

    task automatic tick1();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic trigger_0700();
        do_set_time(8'h06, 8'h59, 8'h59, 1'b0);
        tick1();
    endtask

    // Monitor: compare DUT outputs whenever an expectation is due for this cycle.
    always begin
        exp_t e;
        logic [26:0] act;
        @(posedge clk);
        #2;
        while (sb.size() > 0 && sb[0].tag < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_sample tag=%0d now=%0d expected=%h", e.tag, cyc, e.v);
        end
        if (sb.size() > 0 && sb[0].tag == cyc) begin
            e = sb.pop_front();
            act = {hh, mm, ss, sec_pulse, alarm_active, set_err};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL outputs cyc=%0d got %h:%h:%h sp=%b al=%b err=%b, expected %h:%h:%h sp=%b al=%b err=%b",
                         cyc, act[26:19], act[18:11], act[10:3], act[2], act[1], act[0],
                         e.v[26:19], e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    task automatic async_reset_check();
        logic [26:0] act;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        act = {hh, mm, ss, sec_pulse, alarm_active, set_err};
        checks++;
        if (act !== 27'd0) begin
            errors++;
            $display("FAIL async_reset got=%h expected=0", act);
        end
        t_sec = 0; alm_min = 0; ringing = 0; rcnt = 0; m_pulse = 0; m_err = 0;
        tick = 1'b0; ack = 1'b0; set_time = 1'b0; set_alarm = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();                                  // reset state

        do_set_time(8'h23, 8'h59, 8'h58, 1'b0);  // day wrap
        tick1();
        tick1();
        step();

        do_set_time(8'h12, 8'h09, 8'h59, 1'b0);  // BCD carries
        tick1();
        do_set_time(8'h09, 8'h59, 8'h59, 1'b0);
        tick1();

        do_set_time(8'h24, 8'h00, 8'h00, 1'b0);  // illegal loads
        do_set_time(8'h10, 8'h00, 8'h5A, 1'b1);
        do_set_time(8'h08, 8'h30, 8'h00, 1'b1);  // legal load beats tick
        step();
        do_set_alarm(8'h24, 8'h00);
        set_time = 1'b1; set_hh = 8'h01; set_mm = 8'h02; set_ss = 8'h03;
        set_alarm = 1'b1; alm_hh = 8'h07; alm_mm = 8'h6A;
        step();
        set_time = 1'b0; set_alarm = 1'b0;

        do_set_alarm(8'h07, 8'h00);              // alarm, ack
        alarm_en = 1'b1;
        do_set_time(8'h07, 8'h00, 8'h00, 1'b0);  // loading a match never rings
        step();
        trigger_0700();
        step();
        ack = 1'b1; step(); ack = 1'b0;
        ack = 1'b1; step(); ack = 1'b0;          // ack while idle

        trigger_0700();                          // timeout
        repeat (3) begin tick1(); step(); end
        trigger_0700();                          // alarm_en drop
        alarm_en = 1'b0; step(); alarm_en = 1'b1;
        trigger_0700();                          // ena freezes count
        ena = 1'b0;
        repeat (3) tick1();
        ena = 1'b1;
        repeat (3) tick1();
        do_set_time(8'h06, 8'h59, 8'h59, 1'b0);  // ack on trigger edge
        ack = 1'b1; tick1(); ack = 1'b0;
        step();
        trigger_0700();                          // async reset mid-ring
        async_reset_check();
        step();

        for (int ep = 0; ep < 25; ep++) begin
            int ah, am, ts;
            ah = $urandom_range(0, 23);
            am = $urandom_range(0, 59);
            do_set_alarm(to_bcd(ah), to_bcd(am));
            ts = (ah * 3600 + am * 60 - int'($urandom_range(1, 4)) + 86400) % 86400;
            do_set_time(to_bcd(ts / 3600), to_bcd((ts / 60) % 60), to_bcd(ts % 60), 1'b0);
            for (int k = 0; k < 15; k++) begin
                tick     = 1'($urandom_range(0, 1));
                ena      = ($urandom_range(0, 5) != 0);
                ack      = ($urandom_range(0, 9) == 0);
                alarm_en = ($urandom_range(0, 11) != 0);
                set_time = ($urandom_range(0, 14) == 0);
                set_hh   = 8'($urandom_range(0, 255));
                set_mm   = 8'($urandom_range(0, 255));
                set_ss   = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) begin
                    set_hh = to_bcd($urandom_range(0, 23));
                    set_mm = to_bcd($urandom_range(0, 59));
                    set_ss = to_bcd($urandom_range(0, 59));
                end
                set_alarm = ($urandom_range(0, 14) == 0);
                alm_hh    = 8'($urandom_range(0, 255));
                alm_mm    = 8'($urandom_range(0, 255));
                step();
            end
            tick = 1'b0; ena = 1'b1; ack = 1'b0; alarm_en = 1'b1;
            set_time = 1'b0; set_alarm = 1'b0;
        end

        step();
        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
